disp_scan_mux: RTL and testbench

Parametrised time-multiplexed scanner for common-anode/cathode 7-segment banks. It generalises the fixed 4-digit one-hot rotator to NUM_DIGITS digits and adds:
- an anti-ghosting blank interval;
- an enable;
- frame-coherent data latching;
- hex decode with leading-zero suppression.

It sits between the datapath (BCD/hex nibbles) and the board display pins.

---
 rtl/disp_scan_mux.sv | 137 +++++++++++++
 tb/tb_disp_scan_mux.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_mux.sv
// Time-multiplexed 7-segment scanner: one-hot digit rotation with blanking,
// frame-coherent shadow latching, hex decode and leading-zero suppression.
`timescale 1ns/1ps
module disp_scan_mux #(
  parameter int NUM_DIGITS       = 4,
  parameter int CLK_FREQ_HZ      = 27_000_000,
  parameter int SCAN_HZ          = 1000,
  parameter int BLANK_CYCLES     = 2700,
  parameter int ANODE_ACTIVE_LOW = 0,
  parameter int SEG_ACTIVE_LOW   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          lz_en,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int T     = CLK_FREQ_HZ / SCAN_HZ;
  localparam int CNT_W = $clog2(T);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(T - 1);
  localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]            SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF    = (SEG_ACTIVE_LOW != 0);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    shadow_lz;

  logic [3:0]              nibble;
  logic [NUM_DIGITS:0]     zero_from;
  logic                    suppress;
  logic [NUM_DIGITS-1:0]   onehot;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  // zero_from[i] is set when nibbles i..MSD of the latched frame are all zero.
  always_comb begin
    zero_from             = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      zero_from[i] = zero_from[i+1] && (shadow_digits[4*i +: 4] == 4'h0);
    nibble   = shadow_digits[4*int'(idx) +: 4];
    suppress = shadow_lz && (idx != '0) && zero_from[idx];
    onehot   = NUM_DIGITS'(1) << idx;
  end

  // Outputs are computed from the pre-edge (state, cnt, idx), giving one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shadow_digits <= '0;
      shadow_dp     <= '0;
      shadow_lz     <= 1'b0;
      an            <= AN_OFF;
      seg           <= SEG_OFF;
      dp            <= DP_OFF;
      digit_idx     <= '0;
      frame_tick    <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      digit_idx  <= idx;
      if (state == SCAN && cnt >= CNT_BLANK) begin
        an  <= onehot ^ AN_OFF;
        seg <= (suppress ? 7'h00 : decode(nibble)) ^ SEG_OFF;
        dp  <= shadow_dp[idx] ^ DP_OFF;
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= DP_OFF;
      end

      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state         <= SCAN;
            cnt           <= '0;
            idx           <= '0;
            shadow_digits <= digits;
            shadow_dp     <= dp_in;
            shadow_lz     <= lz_en;
          end
          default: begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (idx == IDX_LAST) begin
                // Frame boundary: the only point where live inputs reach the display.
                idx           <= '0;
                shadow_digits <= digits;
                shadow_dp     <= dp_in;
                shadow_lz     <= lz_en;
                frame_tick    <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Scoreboard bench for disp_scan_mux: a frame-position model pushes expected
// outputs each edge; scenario tasks pop and compare both polarity variants.
`timescale 1ns/1ps
module tb_disp_scan_mux;

  localparam int N     = 4;
  localparam int T     = 10;
  localparam int BLANK = 2;
  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        lz_en;

  logic [3:0] an_h, an_l;
  logic [6:0] seg_h, seg_l;
  logic       dp_h, dp_l;
  logic [1:0] idx_h, idx_l;
  logic       tick_h, tick_l;

  int errors = 0;
  int checks = 0;

  typedef logic [14:0] vec_t;
  vec_t q[$];
  vec_t exp_v;
  vec_t obs_h, obs_l;

  logic        m_run;
  int          m_pos;
  logic [15:0] s_dig;
  logic [3:0]  s_dp;
  logic        s_lz;

  always #5 clk = ~clk;

  disp_scan_mux #(.NUM_DIGITS(N), .CLK_FREQ_HZ(100), .SCAN_HZ(10), .BLANK_CYCLES(BLANK),
                  .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)) dut_high (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in), .lz_en(lz_en),
    .an(an_h), .seg(seg_h), .dp(dp_h), .digit_idx(idx_h), .frame_tick(tick_h));

  disp_scan_mux #(.NUM_DIGITS(N), .CLK_FREQ_HZ(100), .SCAN_HZ(10), .BLANK_CYCLES(BLANK),
                  .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut_low (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in), .lz_en(lz_en),
    .an(an_l), .seg(seg_l), .dp(dp_l), .digit_idx(idx_l), .frame_tick(tick_l));

  assign obs_h = {an_h, seg_h, dp_h, idx_h, tick_h};
  assign obs_l = {an_l, seg_l, dp_l, idx_l, tick_l};

  function automatic vec_t invert(input vec_t v);
    return v ^ {4'hF, 7'h7F, 1'b1, 2'b00, 1'b0};
  endfunction

  // Reference model: tracks position within the frame and predicts the next registered outputs.
  always @(posedge clk or negedge rst_n) begin : model
    int         cnt_m, idx_m;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e, sup;
    if (!rst_n) begin
      m_run <= 1'b0;
      m_pos <= 0;
      s_dig <= '0;
      s_dp  <= '0;
      s_lz  <= 1'b0;
      q.delete();
    end else begin
      cnt_m = m_pos % T;
      idx_m = m_pos / T;
      an_e  = '0;
      seg_e = '0;
      dp_e  = 1'b0;
      if (m_run && cnt_m >= BLANK) begin
        an_e[idx_m] = 1'b1;
        sup   = s_lz && idx_m != 0 && ((s_dig >> (4 * idx_m)) == 16'h0);
        seg_e = sup ? 7'h00 : SEG_TBL[s_dig[4*idx_m +: 4]];
        dp_e  = s_dp[idx_m];
      end
      q.push_back({an_e, seg_e, dp_e, 2'(m_run ? idx_m : 0), m_run && en && m_pos == T*N-1});
      if (!en) begin
        m_run <= 1'b0;
        m_pos <= 0;
      end else if (!m_run || m_pos == T*N-1) begin
        m_run <= 1'b1;
        m_pos <= 0;
        s_dig <= digits;
        s_dp  <= dp_in;
        s_lz  <= lz_en;
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  task automatic test_reset();
    rst_n  = 1'b0;
    en     = 1'b0;
    digits = 16'h1234;
    dp_in  = 4'b0100;
    lz_en  = 1'b0;
    repeat (3) @(negedge clk);
    checks += 2;
    if (obs_h !== 15'h0) begin
      errors++;
      $display("[TB] FAIL reset_high: got %h expected %h", obs_h, 15'h0);
    end
    if (obs_l !== invert(15'h0)) begin
      errors++;
      $display("[TB] FAIL reset_low: got %h expected %h", obs_l, invert(15'h0));
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    int ticks = 0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("[TB] FAIL scan_queue: got empty expected entry");
      end else begin
        exp_v = q.pop_front();
        checks++;
        if (obs_h !== exp_v) begin
          errors++;
          $display("[TB] FAIL scan_high c=%0d: got %h expected %h", c, obs_h, exp_v);
        end
        if (obs_l !== invert(exp_v)) begin
          errors++;
          $display("[TB] FAIL scan_low c=%0d: got %h expected %h", c, obs_l, invert(exp_v));
        end
      end
      if (tick_h) ticks++;
      if (c == 1) en = 1'b1;
    end
    checks++;
    if (ticks !== 2) begin
      errors++;
      $display("[TB] FAIL scan_tick_count: got %0d expected %0d", ticks, 2);
    end
  endtask

  task automatic test_no_tearing();
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("[TB] FAIL tear_queue: got empty expected entry");
      end else begin
        exp_v = q.pop_front();
        checks++;
        if (obs_h !== exp_v) begin
          errors++;
          $display("[TB] FAIL tear_high c=%0d: got %h expected %h", c, obs_h, exp_v);
        end
        if (obs_l !== invert(exp_v)) begin
          errors++;
          $display("[TB] FAIL tear_low c=%0d: got %h expected %h", c, obs_l, invert(exp_v));
        end
      end
      if (c == 14) begin
        digits = 16'hABCD;
        dp_in  = 4'b1001;
      end
    end
  endtask

  task automatic test_lz();
    lz_en  = 1'b1;
    digits = 16'h0050;
    dp_in  = 4'b1000;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("[TB] FAIL lz_queue: got empty expected entry");
      end else begin
        exp_v = q.pop_front();
        checks++;
        if (obs_h !== exp_v) begin
          errors++;
          $display("[TB] FAIL lz_high c=%0d: got %h expected %h", c, obs_h, exp_v);
        end
        if (obs_l !== invert(exp_v)) begin
          errors++;
          $display("[TB] FAIL lz_low c=%0d: got %h expected %h", c, obs_l, invert(exp_v));
        end
      end
      if (c == 55) digits = 16'h0000;
    end
    lz_en  = 1'b0;
    digits = 16'h1234;
    dp_in  = 4'b0100;
  endtask

  task automatic test_en_drop();
    int  c = 0;
    bit  dropped = 0;
    int  after = 0;
    while (after < 60) begin
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("[TB] FAIL endrop_queue: got empty expected entry");
      end else begin
        exp_v = q.pop_front();
        checks++;
        if (obs_h !== exp_v) begin
          errors++;
          $display("[TB] FAIL endrop_high c=%0d: got %h expected %h", c, obs_h, exp_v);
        end
        if (obs_l !== invert(exp_v)) begin
          errors++;
          $display("[TB] FAIL endrop_low c=%0d: got %h expected %h", c, obs_l, invert(exp_v));
        end
      end
      c++;
      if (!dropped && m_run && m_pos == 2*T + 5) begin
        en      = 1'b0;
        dropped = 1;
      end else if (dropped) begin
        after++;
        if (after == 4) en = 1'b1;
      end
      if (!dropped && c > 100) begin
        errors++;
        checks++;
        $display("[TB] FAIL endrop_wait: got no idx2/cnt5 slot expected within 100 cycles");
        after = 60;
      end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("[TB] FAIL arst_queue: got empty expected entry");
      end else begin
        exp_v = q.pop_front();
        checks++;
        if (obs_h !== exp_v) begin
          errors++;
          $display("[TB] FAIL arst_pre_high c=%0d: got %h expected %h", c, obs_h, exp_v);
        end
        if (obs_l !== invert(exp_v)) begin
          errors++;
          $display("[TB] FAIL arst_pre_low c=%0d: got %h expected %h", c, obs_l, invert(exp_v));
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (obs_h !== 15'h0) begin
      errors++;
      $display("[TB] FAIL arst_now_high: got %h expected %h", obs_h, 15'h0);
    end
    if (obs_l !== invert(15'h0)) begin
      errors++;
      $display("[TB] FAIL arst_now_low: got %h expected %h", obs_l, invert(15'h0));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("[TB] FAIL arst_post_queue: got empty expected entry");
      end else begin
        exp_v = q.pop_front();
        checks++;
        if (obs_h !== exp_v) begin
          errors++;
          $display("[TB] FAIL arst_post_high c=%0d: got %h expected %h", c, obs_h, exp_v);
        end
        if (obs_l !== invert(exp_v)) begin
          errors++;
          $display("[TB] FAIL arst_post_low c=%0d: got %h expected %h", c, obs_l, invert(exp_v));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_no_tearing();
    test_lz();
    test_en_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
